// File: rtl/matrix_scan_ctrl_if.sv
// ============================================================================
// Module      : matrix_scan_ctrl_if
// Description : Signal bundle between the matrix scan controller (master) and
//               the downstream pixel data driver / panel pins (slave).
//               en (and brightness when MATRIX_BRIGHT_EN is defined) flow into
//               the controller; coordinates and panel control pins flow out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface matrix_scan_ctrl_if;
    logic       en;          // scan enable
    logic [6:0] col;         // column coordinate to the data driver
    logic [3:0] row;         // row currently being shifted
    logic       mclk;        // panel shift clock
    logic       lat;         // panel latch pulse
    logic       oe_n;        // panel output enable, active-low
    logic [3:0] addr;        // panel row address (row being displayed)
    logic       frame_done;  // one-cycle end-of-frame pulse
    logic       busy;        // high outside IDLE
`ifdef MATRIX_BRIGHT_EN
    logic [2:0] brightness;  // on-time fraction, sampled in LATCH

    modport master (input en, input brightness,
                    output col, output row, output mclk, output lat,
                    output oe_n, output addr, output frame_done, output busy);
    modport slave  (output en, output brightness,
                    input col, input row, input mclk, input lat,
                    input oe_n, input addr, input frame_done, input busy);
`else
    modport master (input en,
                    output col, output row, output mclk, output lat,
                    output oe_n, output addr, output frame_done, output busy);
    modport slave  (output en,
                    input col, input row, input mclk, input lat,
                    input oe_n, input addr, input frame_done, input busy);
`endif
endinterface

`default_nettype wire

// File: rtl/matrix_scan_ctrl.sv
// ============================================================================
// Module      : matrix_scan_ctrl
// Description : Scan/timing generator for a 1/16-scan LED matrix panel.
//               Per row: SHIFT (COLS shift-clock periods) -> LATCH (1 cycle)
//               -> DISPLAY (ON_CYCLES cycles); rows loop 0..ROWS-1.
//               All outputs are registered.
// Ports       : clk  - system clock, rising edge
//               rst  - synchronous active-low reset
//               bus  - matrix_scan_ctrl_if.master (en, col, row, mclk, lat,
//                      oe_n, addr, frame_done, busy [, brightness])
// Options     : MATRIX_BRIGHT_EN - adds brightness[2:0]; oe_n is low only for
//               the first ((brightness+1)*ON_CYCLES)>>3 DISPLAY cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_scan_ctrl #(
    parameter int COLS      = 60,
    parameter int ROWS      = 16,
    parameter int HALF      = 1,
    parameter int ON_CYCLES = 256
) (
    input  wire                 clk,
    input  wire                 rst,
    matrix_scan_ctrl_if.master  bus
);

    // Phase counter spans one full shift-clock period (low + high phase).
    localparam int PW = $clog2(2 * HALF);
    // Display counter: never narrower than 9 bits.
    localparam int DW = ($clog2(ON_CYCLES) > 9) ? $clog2(ON_CYCLES) : 9;
    localparam int LW = DW + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SHIFT   = 2'd1,
        S_LATCH   = 2'd2,
        S_DISPLAY = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   disp_q, disp_d;
    logic [6:0]      col_q, col_d;
    logic [3:0]      row_q, row_d;
    logic [3:0]      addr_q, addr_d;
    logic            mclk_q, mclk_d;
    logic            lat_q, lat_d;
    logic            oe_n_q, oe_n_d;
    logic            fd_q, fd_d;
    logic            busy_q, busy_d;

`ifdef MATRIX_BRIGHT_EN
    logic [LW-1:0]   lim_q, lim_d;
    logic [LW-1:0]   w_lim;
    assign w_lim = LW'(((int'(bus.brightness) + 1) * ON_CYCLES) >> 3);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            disp_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            mclk_q  <= 1'b0;
            lat_q   <= 1'b0;
            oe_n_q  <= 1'b1;
            fd_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifdef MATRIX_BRIGHT_EN
            lim_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            col_q   <= col_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            mclk_q  <= mclk_d;
            lat_q   <= lat_d;
            oe_n_q  <= oe_n_d;
            fd_q    <= fd_d;
            busy_q  <= busy_d;
`ifdef MATRIX_BRIGHT_EN
            lim_q   <= lim_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        mclk_d  = mclk_q;
        lat_d   = 1'b0;
        oe_n_d  = oe_n_q;
        fd_d    = 1'b0;
        busy_d  = busy_q;
`ifdef MATRIX_BRIGHT_EN
        lim_d   = lim_q;
`endif

        case (state_q)
            S_IDLE: begin
                mclk_d = 1'b0;
                col_d  = '0;
                cnt_d  = '0;
                oe_n_d = 1'b1;
                busy_d = 1'b0;
                if (bus.en) begin
                    state_d = S_SHIFT;
                    busy_d  = 1'b1;
                end
            end

            S_SHIFT: begin
                oe_n_d = 1'b1;
                if (cnt_q == PW'(2 * HALF - 1)) begin
                    // End of high phase: drop mclk and advance the column
                    // together so col is stable across the whole period.
                    cnt_d  = '0;
                    mclk_d = 1'b0;
                    if (col_q == 7'(COLS - 1)) begin
                        col_d   = '0;
                        state_d = S_LATCH;
                        lat_d   = 1'b1;
                    end else begin
                        col_d = col_q + 7'd1;
                    end
                end else begin
                    cnt_d = cnt_q + PW'(1);
                    if (cnt_q == PW'(HALF - 1)) begin
                        mclk_d = 1'b1;
                    end
                end
            end

            S_LATCH: begin
                // addr only moves here, while the panel is blanked.
                addr_d  = row_q;
                disp_d  = '0;
                state_d = S_DISPLAY;
`ifdef MATRIX_BRIGHT_EN
                lim_d   = w_lim;
                oe_n_d  = (w_lim == '0);
`else
                oe_n_d  = 1'b0;
`endif
            end

            S_DISPLAY: begin
                if (disp_q == DW'(ON_CYCLES - 1)) begin
                    disp_d = '0;
                    oe_n_d = 1'b1;
                    if (row_q == 4'(ROWS - 1)) begin
                        row_d = '0;
                        fd_d  = 1'b1;
                    end else begin
                        row_d = row_q + 4'd1;
                    end
                    if (bus.en) begin
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    disp_d = disp_q + DW'(1);
`ifdef MATRIX_BRIGHT_EN
                    // Next cycle index is disp_q+1; lit while below the limit.
                    oe_n_d = !((LW'(disp_q) + LW'(1)) < lim_q);
`else
                    oe_n_d = 1'b0;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.col        = col_q;
    assign bus.row        = row_q;
    assign bus.mclk       = mclk_q;
    assign bus.lat        = lat_q;
    assign bus.oe_n       = oe_n_q;
    assign bus.addr       = addr_q;
    assign bus.frame_done = fd_q;
    assign bus.busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_scan_ctrl.sv
// ============================================================================
// Module      : tb_matrix_scan_ctrl
// Description : Scoreboard bench for matrix_scan_ctrl. Expected panel events
//               (mclk edges, latch pulses, display windows, frame pulses,
//               returns to idle) are queued by the stimulus; a monitor turns
//               DUT pin activity into events and compares them in order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matrix_scan_ctrl;

    localparam int K_EDGE = 0;
    localparam int K_LAT  = 1;
    localparam int K_DISP = 2;
    localparam int K_FD   = 3;
    localparam int K_IDLE = 4;
    localparam int ROW_PERIOD = 377;
    localparam int FRAME_PERIOD = 6032;
`ifdef MATRIX_BRIGHT_EN
    localparam int DLEN = 128;
`else
    localparam int DLEN = 256;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    matrix_scan_ctrl_if bus ();

    matrix_scan_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int kind;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    // One row: 60 edges at col 0..59, latch of row r, display window.
    task automatic push_row(input int r, input bit fd, input bit idle);
        for (int k = 0; k < 60; k++) push(K_EDGE, k);
        push(K_LAT, (1 << 8) | r);
        push(K_DISP, (r << 16) | DLEN);
        if (fd)   push(K_FD, FRAME_PERIOD);
        if (idle) push(K_IDLE, (((r + 1) % 16) << 4) | 1);
    endtask

    task automatic emit(input int k, input int v);
        ev_t e;
        string nm;
        case (k)
            K_EDGE:  nm = "mclk_edge";
            K_LAT:   nm = "latch";
            K_DISP:  nm = "display";
            K_FD:    nm = "frame_done";
            default: nm = "idle";
        endcase
        if (exp_q.size() == 0) begin
            check({"unexpected_", nm}, (k << 28) | v, 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check(nm, (k << 28) | v, (e.kind << 28) | e.val);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    logic       p_mclk, p_lat, p_oe_n, p_busy;
    logic [6:0] p_col;
    int         cyc = 0;
    int         last_fd = 0;
    int         lat_run = 0;
    int         lat_row = 0;
    int         disp_run = 0;
    int         disp_addr = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            lat_run  = 0;
            disp_run = 0;
        end else begin
            if (!bus.oe_n) begin
                if (p_oe_n) begin
                    disp_run  = 0;
                    disp_addr = int'(bus.addr);
                end
                disp_run++;
            end else if (!p_oe_n) begin
                emit(K_DISP, (disp_addr << 16) | disp_run);
            end

            if (bus.busy && !p_busy) last_fd = cyc;
            if (bus.frame_done) begin
                emit(K_FD, ((int'(bus.row)) << 16) | (cyc - last_fd));
                last_fd = cyc;
            end

            if (bus.mclk && !p_mclk)
                emit(K_EDGE, int'(bus.col) | ((bus.col != p_col) ? 32'h100 : 0)
                             | ((!bus.oe_n) ? 32'h200 : 0));

            if (bus.lat) begin
                lat_run++;
                lat_row = int'(bus.row);
            end else if (p_lat) begin
                emit(K_LAT, (lat_run << 8) | lat_row);
                lat_run = 0;
            end

            if (!bus.busy && p_busy)
                emit(K_IDLE, ((int'(bus.row)) << 4) | int'(bus.oe_n));
        end
        p_mclk = bus.mclk;
        p_lat  = bus.lat;
        p_oe_n = bus.oe_n;
        p_busy = bus.busy;
        p_col  = bus.col;
    end

    // --------------------------------------------------------------- stimulus
    initial begin
        int n;
        int fds;
        bus.en = 1'b1;
`ifdef MATRIX_BRIGHT_EN
        bus.brightness = 3'd3;
`endif
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_col",  bus.col,  0);
        check("rst_row",  bus.row,  0);
        check("rst_oe_n", bus.oe_n, 1);
        check("rst_lat",  bus.lat,  0);
        check("rst_mclk", bus.mclk, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_addr", bus.addr, 0);
        check("rst_fd",   bus.frame_done, 0);

        // Two full frames, then rows 0..5 of a third with en dropped in row 5.
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < 16; r++) push_row(r, r == 15, 1'b0);
        for (int r = 0; r < 6; r++) push_row(r, 1'b0, r == 5);

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("busy_after_release", bus.busy, 1);
        check("col_after_release",  bus.col,  0);
        check("mclk_after_release", bus.mclk, 0);

        fds = 0;
        n   = 0;
        while (fds < 2 && n < 2 * FRAME_PERIOD + 500) begin
            @(negedge clk);
            if (bus.frame_done) fds++;
            n++;
        end
        check("two_frames_timeout", fds, 2);

        n = 0;
        while (!(bus.row == 4'd5 && bus.col == 7'd20) && n < 6 * ROW_PERIOD) begin
            @(negedge clk);
            n++;
        end
        check("reach_row5_timeout", (bus.row == 4'd5 && bus.col == 7'd20), 1);
        bus.en = 1'b0;

        n = 0;
        while (bus.busy && n < 2 * ROW_PERIOD) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout",  bus.busy, 0);
        check("idle_row",      bus.row,  6);
        check("idle_oe_n",     bus.oe_n, 1);
        check("idle_addr",     bus.addr, 5);
        repeat (20) @(negedge clk);
        check("idle_stays",    bus.busy, 0);
        check("idle_no_mclk",  bus.mclk, 0);

        for (int r = 6; r < 9; r++) push_row(r, 1'b0, 1'b0);
        for (int k = 0; k < 60; k++) push(K_EDGE, k);
        push(K_LAT, (1 << 8) | 9);
        bus.en = 1'b1;

        n = 0;
        while (!(bus.addr == 4'd9 && !bus.oe_n) && n < 5 * ROW_PERIOD) begin
            @(negedge clk);
            n++;
        end
        check("reach_disp9_timeout", (bus.addr == 4'd9 && !bus.oe_n), 1);
        repeat (50) @(negedge clk);
        check("queue_empty_at_reset", exp_q.size(), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_col",  bus.col,  0);
        check("mrst_row",  bus.row,  0);
        check("mrst_oe_n", bus.oe_n, 1);
        check("mrst_lat",  bus.lat,  0);
        check("mrst_mclk", bus.mclk, 0);
        check("mrst_addr", bus.addr, 0);
        check("mrst_busy", bus.busy, 0);
        check("mrst_fd",   bus.frame_done, 0);
        repeat (2) @(posedge clk);

        push_row(0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (bus.col != 7'd10 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("restart_col_timeout", bus.col, 10);
        check("restart_row", bus.row, 0);
        bus.en = 1'b0;

        n = 0;
        while (exp_q.size() != 0 && n < 2 * ROW_PERIOD) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("final_idle",    bus.busy, 0);
        check("final_row",     bus.row,  1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/matrix_scan_ctrl.md
Name: matrix_scan_ctrl

Overview:
- Scan/timing generator for the 60x32 LED matrix panel, which is scanned 1/16 with two halves.
- Sits directly upstream of the pixel data driver: produces the col/row coordinates the driver decodes into R0/G0/B0/R1/G1/B1.
- Also drives the panel control pins: shift clock, latch, output enable and row address.
- Runs a shift -> latch -> display sequence per row and a 16-row frame loop.

Parameters:
- COLS, 60, columns shifted per row; col counts 0..COLS-1.
- ROWS, 16, scan rows per half-panel; row counts 0..ROWS-1.
- HALF, 1, clk cycles per shift-clock phase (low phase and high phase each last HALF cycles).
- ON_CYCLES, 256, clk cycles per row display window.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- en  in  1  scan enable; sampled in IDLE and at the end of each DISPLAY window.
- col  out  7  column coordinate to the data driver.
- row  out  4  row coordinate to the data driver (the row currently being shifted).
- mclk  out  1  panel shift clock; the panel samples RGB data on the rising edge.
- lat  out  1  panel latch pulse.
- oe_n  out  1  panel output enable, active-low.
- addr  out  4  panel row address (the row currently displayed).
- frame_done  out  1  single-cycle pulse at the end of each full frame.
- busy  out  1  high in every state except IDLE.
- brightness  in  3  only present when MATRIX_BRIGHT_EN is defined.

Behaviour:
- Reset (rst=0 at a clk edge) takes effect at that edge, including mid-row.
  - Reset values: col=0, row=0, mclk=0, lat=0, oe_n=1, addr=0, frame_done=0, busy=0, state=IDLE.
- State machine: IDLE, SHIFT, LATCH, DISPLAY. All outputs are registered.
- IDLE:
  - oe_n=1, mclk=0, col=0, row held.
  - If en=1, go to SHIFT next cycle.
- SHIFT:
  - Each column occupies 2*HALF cycles: mclk=0 for HALF cycles with col stable (the driver's combinational data settles), then mclk=1 for HALF cycles.
  - col increments at the end of the high phase; mclk returns to 0 in the same cycle.
  - oe_n=1 throughout SHIFT.
  - After the high phase of col=COLS-1: mclk=0, col=0, go to LATCH.
- LATCH: exactly 1 cycle; lat=1, oe_n=1, addr<=row.
- DISPLAY:
  - lat=0, oe_n=0 for ON_CYCLES cycles.
  - On the last DISPLAY cycle, row increments, wrapping from ROWS-1 to 0.
  - On the wrap from ROWS-1, frame_done=1 for that one cycle.
  - If en=1 at the end of DISPLAY, go to SHIFT; if en=0, go to IDLE with oe_n=1.
- Row timing (defaults): 120 SHIFT + 1 LATCH + 256 DISPLAY = 377 cycles per row; 6032 cycles per frame.
- en deasserted during SHIFT or LATCH does not abort the row; it is acted on only at the end of DISPLAY.
- addr changes only in LATCH, so the panel never displays a partially shifted row.
- col never exceeds COLS-1, so the driver never sees an out-of-range register index.
- The DISPLAY cycle counter is at least 9 bits wide and saturation-free for ON_CYCLES up to 511.

Optional Feature:
- Macro: MATRIX_BRIGHT_EN.
- Defined:
  - The brightness[2:0] port exists and is sampled in LATCH.
  - oe_n=0 only for the first ((brightness+1)*ON_CYCLES)>>3 cycles of DISPLAY, and 1 for the remainder.
  - The DISPLAY window length is unchanged.
  - brightness=7 gives full on-time.
- Not defined: no brightness port; oe_n=0 for the whole DISPLAY window.

Test Plan:
- Reset: hold rst=0 for 3 cycles with en=1 -> col=0, row=0, oe_n=1, lat=0, mclk=0, busy=0. Release -> busy=1 one cycle later and SHIFT starts.
- Single-row timing (defaults, en=1):
  - Exactly 60 mclk rising edges, with col=k stable during the entire low and high phase of edge k.
  - lat=1 for exactly one cycle, addr=0, then oe_n=0 for exactly 256 cycles.
  - Next row begins with row=1.
- Frame wrap: run 6032 cycles -> frame_done pulses exactly once, on the cycle row wraps from 15 to 0; no second pulse for another 6032 cycles.
- en drop: deassert en mid-SHIFT of row 5 -> row 5 completes (60 edges, latch, 256-cycle display), then IDLE with oe_n=1, row=6. Reassert en -> row 6 shifts.
- Mid-operation reset: assert rst=0 during DISPLAY of row 9 -> all outputs at reset values on the next edge; after release, restart from row 0 with the first mclk edge at col=0.
- MATRIX_BRIGHT_EN with brightness=3 -> oe_n=0 for exactly 128 of 256 DISPLAY cycles. brightness=7 -> 256 cycles. Row period stays 377 cycles in both cases.
